// File: rtl/cpu_dispatcher_rr.sv
// Round-robin CPU slot dispatcher with a per-slot resume-address table and a
// small shared data memory served to whichever slot currently holds the grant.
module cpu_dispatcher_rr #(
    parameter int CPU_QUANTITY = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_DEPTH    = 256,
    parameter int QUANTUM      = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CPU_QUANTITY-1:0] cpu_en,
    output logic                    ext_rst_b,
    input  logic                    ext_rst_e,
    output logic [7:0]              cpu_index,
    output logic                    cpu_q,
    output logic [ADDR_W-1:0]       cpu_resume,
    input  logic                    cpu_e,
    output logic                    preempt,
    input  logic                    read_q,
    input  logic                    write_q,
    input  logic [ADDR_W-1:0]       addr_in,
    input  logic [DATA_W-1:0]       data_in,
    output logic                    read_dn,
    output logic                    write_dn,
    output logic [DATA_W-1:0]       data_out,
    output logic                    addr_err,
    output logic                    busy
);
    localparam int IW = (CPU_QUANTITY > 1) ? $clog2(CPU_QUANTITY) : 1;
    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int QW = $clog2(QUANTUM + 1);

    typedef enum logic [2:0] {INIT, WAIT_RST, SELECT, GRANT, SERVE, MEM} state_t;

    state_t            state;
    logic [IW-1:0]     init_cnt;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     last_idx;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     cand;
    logic              pick_vld;
    logic [QW-1:0]     qcnt;
    logic              op_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              lat_bad;
    logic [MW-1:0]     lat_widx;
    logic [ADDR_W-1:0] resume_tbl [CPU_QUANTITY];
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    assign lat_bad  = (lat_addr >= ADDR_W'(MEM_DEPTH));
    assign lat_widx = lat_addr[MW-1:0];

    // Scan from furthest to nearest so the nearest enabled slot after last_idx wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int i = CPU_QUANTITY; i >= 1; i--) begin
            cand = IW'((int'(last_idx) + i) % CPU_QUANTITY);
            if (cpu_en[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            init_cnt   <= '0;
            idx        <= '0;
            last_idx   <= IW'(CPU_QUANTITY - 1);
            qcnt       <= '0;
            ext_rst_b  <= 1'b1;
            cpu_index  <= '0;
            cpu_q      <= 1'b0;
            cpu_resume <= '0;
            preempt    <= 1'b0;
            read_dn    <= 1'b0;
            write_dn   <= 1'b0;
            data_out   <= '0;
            addr_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cpu_q    <= 1'b0;
            read_dn  <= 1'b0;
            write_dn <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                INIT: begin
                    if (init_cnt == IW'(CPU_QUANTITY - 1)) begin
                        state     <= WAIT_RST;
                        ext_rst_b <= 1'b0;
                    end
                    init_cnt <= init_cnt + 1'b1;
                end
                WAIT_RST: begin
                    if (ext_rst_e) begin
                        state <= SELECT;
                        busy  <= 1'b1;
                    end
                end
                SELECT: begin
                    if (pick_vld) begin
                        idx        <= pick;
                        cpu_index  <= 8'(pick);
                        cpu_resume <= resume_tbl[pick];
                        cpu_q      <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    last_idx <= idx;
                    qcnt     <= '0;
                    state    <= SERVE;
                end
                SERVE: begin
                    if (qcnt != QW'(QUANTUM)) qcnt <= qcnt + 1'b1;
                    if (qcnt == QW'(QUANTUM - 1)) preempt <= 1'b1;
                    if (read_q || write_q) begin
                        state <= MEM;
                    end else if (cpu_e) begin
                        preempt <= 1'b0;
                        state   <= SELECT;
                    end
                end
                MEM: begin
                    if (op_wr) begin
                        write_dn <= 1'b1;
                    end else begin
                        read_dn  <= 1'b1;
                        data_out <= lat_bad ? '0 : mem[lat_widx];
                    end
                    addr_err <= lat_bad;
                    state    <= SERVE;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Storage and request latches carry no reset; a reset during MEM moves the
    // state away from MEM before the next edge, so the pending write is dropped.
    always_ff @(posedge clk) begin
        if (state == INIT) resume_tbl[init_cnt] <= '0;
        if (state == SERVE) begin
            if (read_q || write_q) begin
                lat_addr <= addr_in;
                lat_data <= data_in;
                op_wr    <= !read_q;
            end else if (cpu_e) begin
                resume_tbl[idx] <= addr_in;
            end
        end
        if (state == MEM && op_wr && !lat_bad) mem[lat_widx] <= lat_data;
    end

endmodule

// File: tb/tb_cpu_dispatcher_rr.sv
// Randomized and directed bench for cpu_dispatcher_rr, checked against a
// slot/memory model built from the round-robin, quantum and memory rules.
module tb_cpu_dispatcher_rr;
    localparam int NCPU  = 4;
    localparam int IWB   = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int QNT   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCPU-1:0] cpu_en;
    logic            ext_rst_b;
    logic            ext_rst_e;
    logic [7:0]      cpu_index;
    logic            cpu_q;
    logic [AW-1:0]   cpu_resume;
    logic            cpu_e;
    logic            preempt;
    logic            read_q;
    logic            write_q;
    logic [AW-1:0]   addr_in;
    logic [DW-1:0]   data_in;
    logic            read_dn;
    logic            write_dn;
    logic [DW-1:0]   data_out;
    logic            addr_err;
    logic            busy;

    always #5 clk = ~clk;

    cpu_dispatcher_rr #(
        .CPU_QUANTITY(NCPU), .ADDR_W(AW), .DATA_W(DW),
        .MEM_DEPTH(DEPTH), .QUANTUM(QNT)
    ) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .ext_rst_b(ext_rst_b),
        .ext_rst_e(ext_rst_e), .cpu_index(cpu_index), .cpu_q(cpu_q),
        .cpu_resume(cpu_resume), .cpu_e(cpu_e), .preempt(preempt),
        .read_q(read_q), .write_q(write_q), .addr_in(addr_in), .data_in(data_in),
        .read_dn(read_dn), .write_dn(write_dn), .data_out(data_out),
        .addr_err(addr_err), .busy(busy)
    );

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_vld [DEPTH];
    logic [AW-1:0] m_tbl [NCPU];
    int            m_last;
    int            m_cur;
    int            served;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [NCPU-1:0] en, input int last);
        logic [NCPU-1:0] sh;
        for (int i = 1; i <= NCPU; i++) begin
            sh = en >> ((last + i) % NCPU);
            if (sh[0]) return (last + i) % NCPU;
        end
        return -1;
    endfunction

    task automatic assert_rst();
        rst = 1'b1;
        #1;
        chk("rst_ext_rst_b", 64'(ext_rst_b), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_pulses", 64'({cpu_q, read_dn, write_dn, addr_err}), 64'(0));
        chk("rst_preempt", 64'(preempt), 64'(0));
        chk("rst_cpu_index", 64'(cpu_index), 64'(0));
        chk("rst_cpu_resume", 64'(cpu_resume), 64'(0));
        chk("rst_data_out", 64'(data_out), 64'(0));
        m_last = NCPU - 1;
        for (int k = 0; k < NCPU; k++) m_tbl[IWB'(k)] = '0;
        read_q = 1'b0; write_q = 1'b0; cpu_e = 1'b0; ext_rst_e = 1'b0;
    endtask

    task automatic bring_up();
        int n;
        n = 0;
        rst = 1'b0;
        while (ext_rst_b === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("ext_rst_b_cycles", 64'(n), 64'(NCPU));
        tick();
        chk("wait_rst_hold", 64'({ext_rst_b, busy}), 64'(0));
        ext_rst_e = 1'b1;
        tick();
        ext_rst_e = 1'b0;
        chk("busy_up", 64'(busy), 64'(1));
    endtask

    task automatic expect_grant(input int exp_idx);
        int n;
        n = 0;
        while (cpu_q !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("grant_seen", 64'(cpu_q), 64'(1));
        chk("grant_idx", 64'(cpu_index), 64'(exp_idx));
        chk("grant_resume", 64'(cpu_resume), 64'(m_tbl[IWB'(exp_idx)]));
        m_last = exp_idx;
        m_cur  = exp_idx;
        served = 0;
        tick();
        chk("cpu_q_pulse", 64'(cpu_q), 64'(0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk("preempt", 64'(preempt), 64'(served >= QNT));
            tick();
            served++;
        end
    endtask

    task automatic do_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic          bad;
        logic [DW-1:0] exp_d;
        bad = (a >= AW'(DEPTH));
        chk("preempt", 64'(preempt), 64'(served >= QNT));
        read_q = !wr; write_q = wr; addr_in = a; data_in = d;
        tick();
        served++;
        read_q = 1'b0; write_q = 1'b0; addr_in = $urandom; data_in = $urandom;
        chk("done_early", 64'({read_dn, write_dn}), 64'(0));
        tick();
        if (wr) begin
            chk("write_dn", 64'({read_dn, write_dn}), 64'(2'b01));
            if (!bad) begin
                m_mem[a[7:0]] = d;
                m_vld[a[7:0]] = 1'b1;
            end
        end else begin
            exp_d = bad ? '0 : m_mem[a[7:0]];
            chk("read_dn", 64'({read_dn, write_dn}), 64'(2'b10));
            chk("read_data", 64'(data_out), 64'(exp_d));
        end
        chk("addr_err", 64'(addr_err), 64'(bad));
    endtask

    task automatic end_slot(input logic [AW-1:0] resume, input logic [NCPU-1:0] new_en);
        chk("preempt", 64'(preempt), 64'(served >= QNT));
        cpu_e = 1'b1; addr_in = resume; cpu_en = new_en;
        tick();
        cpu_e = 1'b0;
        m_tbl[IWB'(m_cur)] = resume;
        chk("preempt_clr", 64'(preempt), 64'(0));
        chk("idx_hold", 64'(cpu_index), 64'(m_cur));
        chk("busy", 64'(busy), 64'(1));
    endtask

    task automatic random_slots(input int nslots);
        int              nops;
        int              kind;
        logic [AW-1:0]   a;
        logic [NCPU-1:0] en;
        for (int s = 0; s < nslots; s++) begin
            nops = $urandom_range(1, 6);
            for (int o = 0; o < nops; o++) begin
                kind = $urandom_range(0, 3);
                if (kind == 0) begin
                    idle($urandom_range(1, 4));
                end else begin
                    if ($urandom_range(0, 9) == 0) a = AW'(DEPTH) + $urandom_range(0, 100);
                    else a = $urandom_range(0, 15);
                    if (kind == 1 || (a < AW'(DEPTH) && !m_vld[a[7:0]])) do_access(1'b1, a, $urandom);
                    else do_access(1'b0, a, '0);
                end
                if ($urandom_range(0, 4) == 0) cpu_en = NCPU'($urandom);
            end
            en = NCPU'($urandom_range(1, 15));
            end_slot($urandom, en);
            expect_grant(model_pick(en, m_last));
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b0; cpu_en = 4'b1111; ext_rst_e = 1'b0; cpu_e = 1'b0;
        read_q = 1'b0; write_q = 1'b0; addr_in = '0; data_in = '0;
        #2;
        assert_rst();
        tick();
        bring_up();
        expect_grant(0);

        do_access(1'b1, 5, 32'hA5A5A5A5);
        do_access(1'b0, 5, '0);
        do_access(1'b0, AW'(DEPTH), '0);
        do_access(1'b1, AW'(DEPTH + 3), 32'h0BAD0BAD);
        do_access(1'b0, 5, '0);

        end_slot(32'h0, 4'b1010);
        expect_grant(1);
        idle(QNT);
        chk("preempt_rise", 64'(preempt), 64'(1));
        do_access(1'b1, 9, 32'h12345678);
        end_slot(32'h40, 4'b1010);
        expect_grant(3);
        end_slot(32'h0, 4'b1010);
        expect_grant(1);
        chk("resume_0x40", 64'(cpu_resume), 64'(32'h40));
        end_slot(32'h0, 4'b1010);
        expect_grant(3);

        end_slot(32'h77, 4'b0000);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (cpu_q) cnt++;
            tick();
        end
        chk("no_grant_empty", 64'(cnt), 64'(0));
        cpu_en = 4'b0100;
        expect_grant(model_pick(cpu_en, m_last));

        do_access(1'b1, 7, 32'h11111111);
        write_q = 1'b1; addr_in = 7; data_in = 32'hDEADBEEF;
        tick();
        write_q = 1'b0;
        assert_rst();
        tick();
        chk("no_write_dn_rst", 64'(write_dn), 64'(0));
        tick();
        cpu_en = 4'b1111;
        bring_up();
        expect_grant(0);
        do_access(1'b0, 7, '0);

        random_slots(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
